// File: rtl/gp_reg_bank_pkg.sv
// Shared definitions for the GP register bank: register offsets, response codes, decode helpers.
// Optional timer registers are present only when GP_REG_BANK_TIMER_EN is defined.
package gp_reg_bank_pkg;

   localparam logic [31:0] REG_ID        = 32'h00;
   localparam logic [31:0] REG_CTRL      = 32'h04;
   localparam logic [31:0] REG_STATUS    = 32'h08;
   localparam logic [31:0] REG_IRQ_STAT  = 32'h0C;
   localparam logic [31:0] REG_IRQ_EN    = 32'h10;
   localparam logic [31:0] REG_SCRATCH0  = 32'h14;
   localparam logic [31:0] REG_SCRATCH1  = 32'h18;
   localparam logic [31:0] REG_SCRATCH2  = 32'h1C;
   localparam logic [31:0] REG_SCRATCH3  = 32'h20;
   localparam logic [31:0] REG_TIMER_CNT = 32'h24;
   localparam logic [31:0] REG_TIMER_CMP = 32'h28;

   localparam logic [31:0] ID_DEFAULT = 32'h4750_5242;

   localparam logic [1:0] RES_OKAY = 2'b00;
   localparam logic [1:0] RES_ERR  = 2'b10;

   typedef enum logic {ST_IDLE, ST_RESP} fsm_e;

   typedef enum logic [3:0] {
      SEL_NONE, SEL_ID, SEL_CTRL, SEL_STATUS, SEL_IRQ_STAT, SEL_IRQ_EN,
      SEL_SCRATCH0, SEL_SCRATCH1, SEL_SCRATCH2, SEL_SCRATCH3,
      SEL_TIMER_CNT, SEL_TIMER_CMP
   } reg_sel_e;

   // Misaligned byte addresses never match an offset, so they fall out as SEL_NONE.
   function automatic reg_sel_e decode_addr(input logic [31:0] addr);
      reg_sel_e sel;
      case (addr)
         REG_ID:        sel = SEL_ID;
         REG_CTRL:      sel = SEL_CTRL;
         REG_STATUS:    sel = SEL_STATUS;
         REG_IRQ_STAT:  sel = SEL_IRQ_STAT;
         REG_IRQ_EN:    sel = SEL_IRQ_EN;
         REG_SCRATCH0:  sel = SEL_SCRATCH0;
         REG_SCRATCH1:  sel = SEL_SCRATCH1;
         REG_SCRATCH2:  sel = SEL_SCRATCH2;
         REG_SCRATCH3:  sel = SEL_SCRATCH3;
`ifdef GP_REG_BANK_TIMER_EN
         REG_TIMER_CNT: sel = SEL_TIMER_CNT;
         REG_TIMER_CMP: sel = SEL_TIMER_CMP;
`endif
         default:       sel = SEL_NONE;
      endcase
      return sel;
   endfunction

   function automatic logic is_read_only(input reg_sel_e sel);
      return (sel == SEL_ID) || (sel == SEL_STATUS) || (sel == SEL_TIMER_CNT);
   endfunction

   function automatic reg_sel_e scratch_sel(input int idx);
      return reg_sel_e'(int'(SEL_SCRATCH0) + idx);
   endfunction

   function automatic logic [31:0] apply_strobe(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[i*8 +: 8] = strb[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/gp_reg_bank_if.sv
// GP write/read request interface between the AXI-Lite front end (master) and the register bank (slave).
interface gp_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
);
   logic              write;
   logic [ADDR_W-1:0] write_addrs;
   logic [DATA_W-1:0] write_data;
   logic [3:0]        write_strobe;
   logic              write_done;
   logic              write_error;
   logic              read;
   logic [ADDR_W-1:0] read_addrs;
   logic [DATA_W-1:0] read_data;
   logic              read_error;
   logic              read_done;

   modport master (
      output write, write_addrs, write_data, write_strobe, read, read_addrs,
      input  write_done, write_error, read_data, read_error, read_done
   );

   modport slave (
      input  write, write_addrs, write_data, write_strobe, read, read_addrs,
      output write_done, write_error, read_data, read_error, read_done
   );
endinterface

// File: rtl/gp_reg_bank_timer.sv
// Free-running compare timer: counts while enabled, clears and pulses match_o on compare hit.
module gp_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic        en_i,
   input  logic [31:0] cmp_i,
   output logic [31:0] cnt_o,
   output logic        match_o
);
   logic [31:0] cnt_q, cnt_d;

   // Match is gated by enable so a held count equal to the compare value stays silent.
   always_comb begin
      match_o = en_i && (cnt_q == cmp_i);
      cnt_d   = cnt_q;
      if (match_o) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/gp_reg_bank.sv
// GP register bank: decodes GP requests, one-cycle done/error responses, CTRL/scratch/IRQ registers.
// Define GP_REG_BANK_TIMER_EN to include the compare timer at 0x24/0x28.
module gp_reg_bank
   import gp_reg_bank_pkg::*;
#(
   parameter int          GP_ADDR_WIDTH = 6,
   parameter int          DATA_WIDTH    = 32,
   parameter logic [31:0] ID_VALUE      = ID_DEFAULT,
   parameter logic [31:0] CTRL_RESET    = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   gp_if.slave         bus,
   input  logic [31:0] status_in,
   input  logic [7:0]  irq_src,
   output logic [31:0] ctrl_out,
   output logic        irq
);
   fsm_e                     wr_state_q, wr_state_d;
   logic [GP_ADDR_WIDTH-1:0] wr_addr_q;
   logic [DATA_WIDTH-1:0]    wr_data_q;
   logic [3:0]               wr_strb_q;
   reg_sel_e                 wr_sel;
   logic [1:0]               wr_resp;
   logic                     wr_commit;

   fsm_e                     rd_state_q, rd_state_d;
   logic [DATA_WIDTH-1:0]    rd_data_q;
   logic [1:0]               rd_resp_q;
   reg_sel_e                 rd_sel;
   logic [31:0]              rd_val;

   logic [31:0] ctrl_q, ctrl_d;
   logic [7:0]  irq_stat_q, irq_stat_d;
   logic [7:0]  irq_en_q, irq_en_d;
   logic [31:0] scratch_q [4];
   logic [31:0] scratch_d [4];
   logic        irq_q, irq_d;
   logic        unused_src;

   assign unused_src = irq_src[0];

`ifdef GP_REG_BANK_TIMER_EN
   logic [31:0] timer_cmp_q, timer_cmp_d;
   logic [31:0] timer_cnt;
   logic        timer_match;

   gp_timer u_timer (
      .clk     (clk),
      .rst     (rst),
      .en_i    (ctrl_q[0]),
      .cmp_i   (timer_cmp_q),
      .cnt_o   (timer_cnt),
      .match_o (timer_match)
   );
`endif

   always_comb begin
      wr_state_d = ST_IDLE;
      if (wr_state_q == ST_IDLE && bus.write) begin
         wr_state_d = ST_RESP;
      end
      rd_state_d = ST_IDLE;
      if (rd_state_q == ST_IDLE && bus.read) begin
         rd_state_d = ST_RESP;
      end
   end

   assign wr_sel    = decode_addr(32'(wr_addr_q));
   assign wr_resp   = (wr_sel == SEL_NONE || is_read_only(wr_sel)) ? RES_ERR : RES_OKAY;
   assign wr_commit = (wr_state_q == ST_RESP) && (wr_resp == RES_OKAY);

   assign bus.write_done  = (wr_state_q == ST_RESP);
   assign bus.write_error = (wr_state_q == ST_RESP) && (wr_resp != RES_OKAY);
   assign bus.read_done   = (rd_state_q == ST_RESP);
   assign bus.read_error  = (rd_state_q == ST_RESP) && (rd_resp_q != RES_OKAY);
   assign bus.read_data   = (rd_state_q == ST_RESP) ? rd_data_q : '0;

   assign rd_sel = decode_addr(32'(bus.read_addrs));

   always_comb begin
      rd_val = '0;
      case (rd_sel)
         SEL_ID:        rd_val = ID_VALUE;
         SEL_CTRL:      rd_val = ctrl_q;
         SEL_STATUS:    rd_val = status_in;
         SEL_IRQ_STAT:  rd_val = {24'h0, irq_stat_q};
         SEL_IRQ_EN:    rd_val = {24'h0, irq_en_q};
         SEL_SCRATCH0:  rd_val = scratch_q[0];
         SEL_SCRATCH1:  rd_val = scratch_q[1];
         SEL_SCRATCH2:  rd_val = scratch_q[2];
         SEL_SCRATCH3:  rd_val = scratch_q[3];
`ifdef GP_REG_BANK_TIMER_EN
         SEL_TIMER_CNT: rd_val = timer_cnt;
         SEL_TIMER_CMP: rd_val = timer_cmp_q;
`endif
         default:       rd_val = '0;
      endcase
   end

   always_comb begin
      ctrl_d     = ctrl_q;
      irq_en_d   = irq_en_q;
      irq_stat_d = irq_stat_q;
      scratch_d  = scratch_q;
      if (wr_commit && wr_sel == SEL_CTRL) begin
         ctrl_d = apply_strobe(ctrl_q, wr_data_q, wr_strb_q);
      end
      if (wr_commit && wr_sel == SEL_IRQ_EN && wr_strb_q[0]) begin
         irq_en_d = wr_data_q[7:0];
      end
      if (wr_commit && wr_sel == SEL_IRQ_STAT && wr_strb_q[0]) begin
         irq_stat_d = irq_stat_q & ~wr_data_q[7:0];
      end
      for (int i = 0; i < 4; i++) begin
         if (wr_commit && wr_sel == scratch_sel(i)) begin
            scratch_d[i] = apply_strobe(scratch_q[i], wr_data_q, wr_strb_q);
         end
      end
      // Sources are applied after the W1C clear so a live source wins.
      irq_stat_d[7:1] = irq_stat_d[7:1] | irq_src[7:1];
`ifdef GP_REG_BANK_TIMER_EN
      irq_stat_d[0] = irq_stat_d[0] | timer_match;
      timer_cmp_d   = timer_cmp_q;
      if (wr_commit && wr_sel == SEL_TIMER_CMP) begin
         timer_cmp_d = apply_strobe(timer_cmp_q, wr_data_q, wr_strb_q);
      end
`else
      irq_stat_d[0] = 1'b0;
`endif
      irq_d = |(irq_stat_q & irq_en_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_state_q <= ST_IDLE;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         wr_strb_q  <= '0;
         rd_state_q <= ST_IDLE;
         rd_data_q  <= '0;
         rd_resp_q  <= RES_OKAY;
      end else begin
         wr_state_q <= wr_state_d;
         rd_state_q <= rd_state_d;
         if (wr_state_q == ST_IDLE && bus.write) begin
            wr_addr_q <= bus.write_addrs;
            wr_data_q <= bus.write_data;
            wr_strb_q <= bus.write_strobe;
         end
         if (rd_state_q == ST_IDLE && bus.read) begin
            rd_data_q <= (rd_sel == SEL_NONE) ? '0 : rd_val;
            rd_resp_q <= (rd_sel == SEL_NONE) ? RES_ERR : RES_OKAY;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q     <= CTRL_RESET;
         irq_stat_q <= '0;
         irq_en_q   <= '0;
         irq_q      <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            scratch_q[i] <= '0;
         end
`ifdef GP_REG_BANK_TIMER_EN
         timer_cmp_q <= '0;
`endif
      end else begin
         ctrl_q     <= ctrl_d;
         irq_stat_q <= irq_stat_d;
         irq_en_q   <= irq_en_d;
         irq_q      <= irq_d;
         scratch_q  <= scratch_d;
`ifdef GP_REG_BANK_TIMER_EN
         timer_cmp_q <= timer_cmp_d;
`endif
      end
   end

   assign ctrl_out = ctrl_q;
   assign irq      = irq_q;
endmodule
